ysyx_23060124_rf_wb_scheduler: RTL and testbench

//  Write-back scheduler and scoreboard for the single-write-port register file.

---
 rtl/ysyx_23060124_rf_wb_scheduler.sv | 121 ++++++++++++
 tb/tb_ysyx_23060124_rf_wb_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_rf_wb_scheduler.sv
// Write-back scheduler and scoreboard for the single-write-port register file.
// Arbitrates ALU/LSU results round-robin onto one registered RF write port and
// tracks pending destinations so decode stalls on RAW/WAW hazards.
// Optional feature macro: YSYX_23060124_WB_BYPASS_EN (waives source hazards
// against the register being written this cycle and exposes bypass outputs).
module ysyx_23060124_rf_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic              iss_rd_wen,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic [ADDR_W-1:0] iss_rs2,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
`ifdef YSYX_23060124_WB_BYPASS_EN
  output logic              byp1_en,
  output logic              byp2_en,
  output logic [DATA_W-1:0] byp_data,
`endif
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              sb_idle
);

  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic              r_rr_ptr;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_contend;
  logic              w_accept;
  logic [ADDR_W-1:0] w_grd;
  logic [DATA_W-1:0] w_gdata;
  logic              w_haz1;
  logic              w_haz2;
  logic              w_hazd;
  logic              w_iss_fire;
  logic              w_hit1;
  logic              w_hit2;

  // Round-robin grant: rr_ptr only matters when both sources want the port.
  assign w_contend = alu_valid & lsu_valid;
  assign alu_ready = alu_valid & (~lsu_valid | ~r_rr_ptr);
  assign lsu_ready = lsu_valid & (~alu_valid |  r_rr_ptr);
  assign w_accept  = alu_ready | lsu_ready;
  assign w_grd     = lsu_ready ? lsu_rd   : alu_rd;
  assign w_gdata   = lsu_ready ? lsu_data : alu_data;

`ifdef YSYX_23060124_WB_BYPASS_EN
  // A source being written this cycle can be read through the bypass instead.
  assign w_hit1   = r_wen & (r_waddr == iss_rs1) & (r_waddr != '0);
  assign w_hit2   = r_wen & (r_waddr == iss_rs2) & (r_waddr != '0);
  assign byp1_en  = w_hit1;
  assign byp2_en  = w_hit2;
  assign byp_data = r_wdata;
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  // Sources are checked whether or not the instruction actually uses them.
  assign w_haz1     = (iss_rs1 != '0) & r_busy[iss_rs1] & ~w_hit1;
  assign w_haz2     = (iss_rs2 != '0) & r_busy[iss_rs2] & ~w_hit2;
  assign w_hazd     = iss_rd_wen & (iss_rd != '0) & r_busy[iss_rd];
  assign iss_stall  = iss_valid & (w_haz1 | w_haz2 | w_hazd);
  assign w_iss_fire = iss_valid & ~iss_stall;

  // Scoreboard update: clear on the RF write edge, then set so a same-cycle set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wen) w_busy_nxt[r_waddr] = 1'b0;
    if (w_iss_fire & iss_rd_wen & (iss_rd != '0)) w_busy_nxt[iss_rd] = 1'b1;
  end

  // Scoreboard and round-robin pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_rr_ptr <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_contend) r_rr_ptr <= ~r_rr_ptr;
    end
  end

  // Registered RF write port; x0 results are consumed but never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_accept & (w_grd != '0);
      if (w_accept) begin
        r_waddr <= w_grd;
        r_wdata <= w_gdata;
      end
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign sb_idle  = ~|r_busy & ~r_wen;

endmodule

// File: tb/tb_ysyx_23060124_rf_wb_scheduler.sv
// Self-checking bench for the write-back scheduler: directed table, reset
// sequence, then random traffic against a behavioural scoreboard model.
module tb_ysyx_23060124_rf_wb_scheduler;

  logic        clk;
  logic        rst_n;
  logic        iss_valid, iss_rd_wen;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_idle;
`ifdef YSYX_23060124_WB_BYPASS_EN
  logic        byp1_en, byp2_en;
  logic [31:0] byp_data;
`endif

  int errors = 0;
  int checks = 0;

  ysyx_23060124_rf_wb_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd_wen(iss_rd_wen), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
`ifdef YSYX_23060124_WB_BYPASS_EN
    .byp1_en(byp1_en), .byp2_en(byp2_en), .byp_data(byp_data),
`endif
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_idle(sb_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int iv, input int rdw, input int rd, input int rs1, input int rs2,
                       input int av, input int ard, input logic [31:0] ad,
                       input int lv, input int lrd, input logic [31:0] ld);
    iss_valid = 1'(iv); iss_rd_wen = 1'(rdw);
    iss_rd = 5'(rd); iss_rs1 = 5'(rs1); iss_rs2 = 5'(rs2);
    alu_valid = 1'(av); alu_rd = 5'(ard); alu_data = ad;
    lsu_valid = 1'(lv); lsu_rd = 5'(lrd); lsu_data = ld;
  endtask

  typedef struct {
    int iv, rdw, rd, rs1, rs2;
    int av, ard; logic [31:0] ad;
    int lv, lrd; logic [31:0] ld;
    logic e_st, e_ar, e_lr, e_wen;
    logic [4:0] e_wa; logic [31:0] e_wd;
    logic e_idle, chk_wd;
  } vec_t;

  function automatic vec_t mk(int iv, int rdw, int rd, int rs1, int rs2,
                              int av, int ard, logic [31:0] ad, int lv, int lrd, logic [31:0] ld,
                              int st, int ar, int lr, int wen, int wa, logic [31:0] wd,
                              int idle, int cw);
    vec_t v;
    v.iv = iv; v.rdw = rdw; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.e_st = 1'(st); v.e_ar = 1'(ar); v.e_lr = 1'(lr); v.e_wen = 1'(wen);
    v.e_wa = 5'(wa); v.e_wd = wd; v.e_idle = 1'(idle); v.chk_wd = 1'(cw);
    return v;
  endfunction

  // Behavioural model state
  bit          m_busy[32];
  int          m_pref;      // 0: ALU wins a tie, 1: LSU wins
  bit          m_wen;
  int          m_waddr;
  logic [31:0] m_wdata;

  function automatic bit m_hit(int rs);
`ifdef YSYX_23060124_WB_BYPASS_EN
    return m_wen && m_waddr == rs && rs != 0;
`else
    return (rs < 0);
`endif
  endfunction

  function automatic bit m_idle();
    for (int i = 0; i < 32; i++) if (m_busy[i]) return 1'b0;
    return !m_wen;
  endfunction

  vec_t tbl[22];
  int   st3;

  initial begin
`ifdef YSYX_23060124_WB_BYPASS_EN
    st3 = 0;
`else
    st3 = 1;
`endif
    tbl[0]  = mk(0,0,0,0,0, 0,0,0,          0,0,0,  0,0,0,0,0,0,1,1);
    tbl[1]  = mk(1,1,5,0,0, 0,0,0,          0,0,0,  0,0,0,0,0,0,1,1);
    tbl[2]  = mk(1,0,0,5,0, 1,5,32'hDEADBEEF,0,0,0, 1,1,0,0,0,0,0,1);
    tbl[3]  = mk(1,0,0,5,0, 0,0,0,          0,0,0,  st3,0,0,1,5,32'hDEADBEEF,0,1);
    tbl[4]  = mk(1,0,0,5,0, 0,0,0,          0,0,0,  0,0,0,0,5,32'hDEADBEEF,1,1);
    tbl[5]  = mk(0,0,0,0,0, 1,1,32'h11,     1,2,32'h22, 0,1,0,0,5,32'hDEADBEEF,1,1);
    tbl[6]  = mk(0,0,0,0,0, 1,1,32'h11,     1,2,32'h22, 0,0,1,1,1,32'h11,0,1);
    tbl[7]  = mk(0,0,0,0,0, 1,1,32'h11,     1,2,32'h22, 0,1,0,1,2,32'h22,0,1);
    tbl[8]  = mk(0,0,0,0,0, 1,1,32'h11,     1,2,32'h22, 0,0,1,1,1,32'h11,0,1);
    tbl[9]  = mk(0,0,0,0,0, 1,0,32'h1234,   0,0,0,  0,1,0,1,2,32'h22,0,1);
    tbl[10] = mk(0,0,0,0,0, 0,0,0,          0,0,0,  0,0,0,0,0,0,1,0);
    tbl[11] = mk(1,1,7,0,0, 0,0,0,          0,0,0,  0,0,0,0,0,0,1,0);
    tbl[12] = mk(1,1,7,0,0, 1,7,32'h77,     0,0,0,  1,1,0,0,0,0,0,0);
    tbl[13] = mk(1,1,7,0,0, 0,0,0,          0,0,0,  1,0,0,1,7,32'h77,0,1);
    tbl[14] = mk(0,0,0,0,0, 0,0,0,          0,0,0,  0,0,0,0,7,32'h77,1,1);
    tbl[15] = mk(0,0,0,0,0, 1,3,32'h33,     0,0,0,  0,1,0,0,7,32'h77,1,1);
    tbl[16] = mk(1,1,3,0,0, 0,0,0,          0,0,0,  0,0,0,1,3,32'h33,0,1);
    tbl[17] = mk(0,0,0,0,0, 0,0,0,          0,0,0,  0,0,0,0,3,32'h33,0,1);
    tbl[18] = mk(1,0,0,0,3, 0,0,0,          0,0,0,  1,0,0,0,3,32'h33,0,1);
    tbl[19] = mk(0,0,0,0,0, 1,3,32'h44,     0,0,0,  0,1,0,0,3,32'h33,0,1);
    tbl[20] = mk(0,0,0,0,0, 0,0,0,          0,0,0,  0,0,0,1,3,32'h44,0,1);
    tbl[21] = mk(0,0,0,0,0, 0,0,0,          0,0,0,  0,0,0,0,3,32'h44,1,1);

    rst_n = 1'b0;
    drive(0,0,0,0,0, 0,0,0, 0,0,0);
    #12;
    chk("reset_wen", 32'(rf_wen), 0);
    chk("reset_waddr", 32'(rf_waddr), 0);
    chk("reset_wdata", rf_wdata, 0);
    chk("reset_idle", 32'(sb_idle), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].rdw, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
            tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      #1;
      chk($sformatf("tbl%0d_stall", i), 32'(iss_stall), 32'(tbl[i].e_st));
      chk($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      chk($sformatf("tbl%0d_lsu_ready", i), 32'(lsu_ready), 32'(tbl[i].e_lr));
      chk($sformatf("tbl%0d_wen", i), 32'(rf_wen), 32'(tbl[i].e_wen));
      chk($sformatf("tbl%0d_idle", i), 32'(sb_idle), 32'(tbl[i].e_idle));
      if (tbl[i].chk_wd) begin
        chk($sformatf("tbl%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_wa));
        chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].e_wd);
      end
`ifdef YSYX_23060124_WB_BYPASS_EN
      if (i == 3) chk("tbl3_byp1_en", 32'(byp1_en), 1);
`endif
    end

    // Async reset in the middle of a pending write
    @(negedge clk);
    drive(1,1,9,0,0, 1,9,32'h99, 0,0,0);
    @(posedge clk);
    #2;
    chk("prereset_wen", 32'(rf_wen), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_wen", 32'(rf_wen), 0);
    chk("midreset_idle", 32'(sb_idle), 1);
    drive(0,0,0,0,0, 1,1,32'h1, 1,2,32'h2);
    #1;
    chk("midreset_alu_first", 32'(alu_ready), 1);
    chk("midreset_lsu_held", 32'(lsu_ready), 0);
    drive(0,0,0,0,0, 0,1,32'h1, 1,2,32'h2);
    #1;
    chk("midreset_lsu_alone", 32'(lsu_ready), 1);
    @(negedge clk);
    drive(0,0,0,0,0, 0,0,0, 0,0,0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1,0,0,9,0, 0,0,0, 0,0,0);
    #1;
    chk("postreset_busy9_clear", 32'(iss_stall), 0);
    chk("postreset_wen", 32'(rf_wen), 0);

    // Random traffic against the model (DUT is in reset state here)
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_pref = 0; m_wen = 1'b0; m_waddr = 0; m_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      int iv, rdw, rd, rs1, rs2, av, ard, lv, lrd, grant, grd;
      logic [31:0] ad, ld, gdata;
      bit st, haz1, haz2, hazd;
      iv  = int'($urandom_range(0, 1)); rdw = int'($urandom_range(0, 1));
      rd  = int'($urandom_range(0, 7)); rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      av  = ($urandom_range(0, 2) != 0) ? 1 : 0; ard = int'($urandom_range(0, 7));
      lv  = ($urandom_range(0, 2) == 0) ? 1 : 0; lrd = int'($urandom_range(0, 7));
      ad  = $urandom; ld = $urandom;
      @(negedge clk);
      drive(iv, rdw, rd, rs1, rs2, av, ard, ad, lv, lrd, ld);
      #1;
      haz1 = rs1 != 0 && m_busy[rs1] && !m_hit(rs1);
      haz2 = rs2 != 0 && m_busy[rs2] && !m_hit(rs2);
      hazd = rdw != 0 && rd != 0 && m_busy[rd];
      st = (iv != 0) && (haz1 || haz2 || hazd);
      if (av != 0 && lv != 0) grant = (m_pref == 0) ? 1 : 2;
      else if (av != 0)       grant = 1;
      else if (lv != 0)       grant = 2;
      else                    grant = 0;
      chk("rnd_stall", 32'(iss_stall), 32'(st));
      chk("rnd_alu_ready", 32'(alu_ready), (grant == 1) ? 1 : 0);
      chk("rnd_lsu_ready", 32'(lsu_ready), (grant == 2) ? 1 : 0);
      chk("rnd_wen", 32'(rf_wen), 32'(m_wen));
      chk("rnd_idle", 32'(sb_idle), 32'(m_idle()));
      if (m_wen) begin
        chk("rnd_waddr", 32'(rf_waddr), 32'(m_waddr));
        chk("rnd_wdata", rf_wdata, m_wdata);
      end
`ifdef YSYX_23060124_WB_BYPASS_EN
      chk("rnd_byp1", 32'(byp1_en), 32'(m_hit(rs1)));
      chk("rnd_byp2", 32'(byp2_en), 32'(m_hit(rs2)));
      if (m_hit(rs1) || m_hit(rs2)) chk("rnd_byp_data", byp_data, m_wdata);
`endif
      // Advance the model across the coming clock edge
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (iv != 0 && !st && rdw != 0 && rd != 0) m_busy[rd] = 1'b1;
      grd   = (grant == 2) ? lrd : ard;
      gdata = (grant == 2) ? ld : ad;
      if (grant != 0) begin
        m_wen = (grd != 0); m_waddr = grd; m_wdata = gdata;
      end else begin
        m_wen = 1'b0;
      end
      if (av != 0 && lv != 0) m_pref = 1 - m_pref;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
